// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-add 4x4 multiplier:
// operand width, iteration count and FSM state encoding.
package mult_seq_pkg;

    localparam int W          = 4;
    localparam int MULT_ITERS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [W-1:0] operand_t;

endpackage

// File: rtl/binary_4_bit_adder_v.sv
// 4-bit + 4-bit unsigned adder with a 5-bit sum; the single shared
// datapath adder that the sequential multiplier reuses every iteration.
module binary_4_bit_adder_v
    import mult_seq_pkg::*;
(
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i0,
    output logic [W:0]   f
);

    assign f = {1'b0, i1} + {1'b0, i0};

endmodule

// File: rtl/multiplier_4_bit_seq_ctrl_v.sv
// Sequential shift-add 4x4 unsigned multiplier controller.
// One adder is time-multiplexed over up to MULT_ITERS iterations; a
// start/ready handshake accepts operands and a valid/ack handshake
// delivers the product as high/low nibbles.
// EARLY_DONE=1 finishes as soon as the unprocessed multiplier bits are zero.
// Optional: define MULT_SEQ_CYCLE_COUNT_EN to add o_cycles, the number of
// BUSY cycles used by the last result.
module multiplier_4_bit_seq_ctrl_v
    import mult_seq_pkg::*;
#(
    parameter int EARLY_DONE = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_au,
    input  logic [W-1:0] i_bu,
    output logic         o_ready,
    output logic         o_valid,
    input  logic         i_ack,
    output logic [W-1:0] o_fu0,
    output logic [W-1:0] o_fu1
`ifdef MULT_SEQ_CYCLE_COUNT_EN
    ,
    output logic [2:0]   o_cycles
`endif
);

    logic [1:0]     state;
    operand_t       a_reg;      // multiplicand
    operand_t       q_reg;      // multiplier, shifting right; low product bits fill from the top
    operand_t       p_reg;      // running partial product, high half
    logic [1:0]     k;          // iteration index 0..3
    operand_t       add_i1;
    logic [W:0]     sum;
    logic [3:0]     rem_mask;
    logic           early_hit;
    logic [2:0]     shift_amt;
    logic [2*W-1:0] early_prod;

    // Select the addend: the multiplicand when the current multiplier bit is set.
    always_comb begin
        // NOTE: assign a default first in every always_comb so no path leaves a signal unassigned and infers a latch.
        add_i1 = '0;
        if (q_reg[0]) add_i1 = a_reg;
    end

    binary_4_bit_adder_v u_adder (
        .i1 (add_i1),
        .i0 (p_reg),
        .f  (sum)
    );

    // Remaining multiplier bits are Q[3-k:0]; once they are all zero the
    // accumulated product is {P, Q[3:4-k]}, i.e. {P,Q} >> (4-k).
    assign rem_mask   = 4'hF >> k;
    assign early_hit  = (EARLY_DONE != 0) && ((q_reg & rem_mask) == 4'd0);
    assign shift_amt  = 3'(MULT_ITERS) - {1'b0, k};
    assign early_prod = {p_reg, q_reg} >> shift_amt;

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);

    // FSM, shift registers and result registers; reset discards any operation in flight.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            q_reg    <= '0;
            p_reg    <= '0;
            k        <= '0;
            o_fu0    <= '0;
            o_fu1    <= '0;
`ifdef MULT_SEQ_CYCLE_COUNT_EN
            o_cycles <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        a_reg <= i_au;
                        q_reg <= i_bu;
                        p_reg <= '0;
                        k     <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (early_hit) begin
                        {o_fu1, o_fu0} <= early_prod;
`ifdef MULT_SEQ_CYCLE_COUNT_EN
                        o_cycles <= {1'b0, k} + 3'd1;
`endif
                        state <= ST_DONE;
                    end else begin
                        p_reg <= sum[W:1];
                        q_reg <= {sum[0], q_reg[W-1:1]};
                        k     <= k + 2'd1;
                        if (k == 2'(MULT_ITERS - 1)) begin
                            o_fu1 <= sum[W:1];
                            o_fu0 <= {sum[0], q_reg[W-1:1]};
`ifdef MULT_SEQ_CYCLE_COUNT_EN
                            o_cycles <= 3'(MULT_ITERS);
`endif
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_4_bit_seq_ctrl_v.sv
// Directed bench for multiplier_4_bit_seq_ctrl_v. Instance 0 runs with
// EARLY_DONE=0, instance 1 with EARLY_DONE=1; both share clock and reset.
// Defining MULT_SEQ_CYCLE_COUNT_EN also checks o_cycles.
module tb_multiplier_4_bit_seq_ctrl_v;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       ack   [2];
    logic [3:0] au    [2];
    logic [3:0] bu    [2];
    logic       ready [2];
    logic       valid [2];
    logic [3:0] fu0   [2];
    logic [3:0] fu1   [2];
`ifdef MULT_SEQ_CYCLE_COUNT_EN
    logic [2:0] cyc   [2];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multiplier_4_bit_seq_ctrl_v #(.EARLY_DONE(0)) u_dut0 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start[0]),
        .i_au    (au[0]),
        .i_bu    (bu[0]),
        .o_ready (ready[0]),
        .o_valid (valid[0]),
        .i_ack   (ack[0]),
        .o_fu0   (fu0[0]),
        .o_fu1   (fu1[0])
`ifdef MULT_SEQ_CYCLE_COUNT_EN
        ,
        .o_cycles (cyc[0])
`endif
    );

    multiplier_4_bit_seq_ctrl_v #(.EARLY_DONE(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start[1]),
        .i_au    (au[1]),
        .i_bu    (bu[1]),
        .o_ready (ready[1]),
        .o_valid (valid[1]),
        .i_ack   (ack[1]),
        .o_fu0   (fu0[1]),
        .o_fu1   (fu1[1])
`ifdef MULT_SEQ_CYCLE_COUNT_EN
        ,
        .o_cycles (cyc[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // BUSY cycles expected: 4 without early termination; otherwise one check
    // cycle after the highest set multiplier bit has been processed, capped at 4.
    function automatic int exp_cycles(input logic [3:0] b, input int early);
        int msb;
        if (early == 0) return 4;
        if (b == 4'd0) return 1;
        msb = 0;
        for (int i = 0; i < 4; i++) if (b[i]) msb = i;
        return (msb + 2 > 4) ? 4 : msb + 2;
    endfunction

    // One full transaction: accept, wait for valid (bounded), check, ack after ack_dly cycles.
    task automatic do_op(input int sel, input logic [3:0] a, input logic [3:0] b,
                         input int ack_dly, input string tag);
        int         n;
        int         exp_n;
        logic [7:0] exp_p;
        exp_p = 8'(a) * 8'(b);
        exp_n = exp_cycles(b, sel);
        @(negedge clk);
        check($sformatf("%s_ready_pre", tag), 32'(ready[sel]), 32'd1);
        au[sel]    = a;
        bu[sel]    = b;
        start[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[sel] = 1'b0;
        n = 0;
        while (!valid[sel] && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check($sformatf("%s_lat %0d*%0d", tag, a, b), 32'(n), 32'(exp_n));
        check($sformatf("%s_prod %0d*%0d", tag, a, b), 32'({fu1[sel], fu0[sel]}), 32'(exp_p));
`ifdef MULT_SEQ_CYCLE_COUNT_EN
        check($sformatf("%s_cycles %0d*%0d", tag, a, b), 32'(cyc[sel]), 32'(exp_n));
`endif
        repeat (ack_dly) @(negedge clk);
        check($sformatf("%s_valid_held", tag), 32'(valid[sel]), 32'd1);
        ack[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack[sel] = 1'b0;
        check($sformatf("%s_ready_post", tag), 32'(ready[sel]), 32'd1);
        check($sformatf("%s_valid_post", tag), 32'(valid[sel]), 32'd0);
        check($sformatf("%s_prod_kept", tag), 32'({fu1[sel], fu0[sel]}), 32'(exp_p));
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b1;
            ack[s]   = 1'b0;
            au[s]    = 4'd9;
            bu[s]    = 4'd7;
        end

        // Reset wins over a simultaneous start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 32'(ready[s]), 32'd1);
            check("rst_valid", 32'(valid[s]), 32'd0);
            check("rst_prod", 32'({fu1[s], fu0[s]}), 32'd0);
`ifdef MULT_SEQ_CYCLE_COUNT_EN
            check("rst_cycles", 32'(cyc[s]), 32'd0);
`endif
            start[s] = 1'b0;
        end
        rst = 1'b0;

        // 15*15 = 0xE1 in exactly 4 cycles.
        do_op(0, 4'd15, 4'd15, 0, "f15");

        // 9*7 = 0x3F held through 10 cycles of start toggling with new operands.
        @(negedge clk);
        au[0] = 4'd9; bu[0] = 4'd7; start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(valid[0]), 32'd1);
            check("hold_ready", 32'(ready[0]), 32'd0);
            check("hold_prod", 32'({fu1[0], fu0[0]}), 32'h3F);
            start[0] = i[0];
            au[0]    = 4'(i + 3);
            bu[0]    = 4'(i + 5);
        end
        @(negedge clk);
        check("hold_prod_end", 32'({fu1[0], fu0[0]}), 32'h3F);
        start[0] = 1'b0;
        ack[0]   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack[0] = 1'b0;
        check("hold_ack_ready", 32'(ready[0]), 32'd1);
        check("hold_ack_prod", 32'({fu1[0], fu0[0]}), 32'h3F);

        // Reset after 2 BUSY cycles discards the operation and clears the result.
        au[0] = 4'd9; bu[0] = 4'd7; start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(ready[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(ready[0]), 32'd1);
        check("midrst_valid", 32'(valid[0]), 32'd0);
        check("midrst_prod", 32'({fu1[0], fu0[0]}), 32'd0);
        do_op(0, 4'd3, 4'd5, 1, "after_rst");

        // Early termination boundaries.
        do_op(1, 4'd7,  4'd0, 0, "ed_7x0");
        do_op(1, 4'd5,  4'd1, 0, "ed_5x1");
        do_op(1, 4'd3,  4'd2, 0, "ed_3x2");
        do_op(1, 4'd3,  4'd6, 0, "ed_3x6");
        do_op(1, 4'd15, 4'd8, 2, "ed_15x8");

        // Exhaustive operand sweep for both configurations.
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    do_op(s, 4'(x), 4'(y), int'($urandom_range(0, 3)), "exh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
